// File: rtl/key_evt_pkg.sv
// Shared types and constants for the key event sequencer.
//   state_e    : sequencer FSM states
//   ADDR_*     : PIO register addresses (data, IRQ mask, edge capture)
//   TS_W       : timestamp width
//   evt_width(): event word width for a given key count
// Optional feature macro: KEY_EVT_TIMESTAMP_EN (adds a TS_W-bit timestamp to each event).
package key_evt_pkg;

  typedef enum logic [3:0] {
    StInitMask,
    StInitClr,
    StIdle,
    StRdCap,
    StCapWait,
    StClr,
    StRdDat,
    StDatWait,
    StPush
  } state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  localparam int unsigned TS_W = 16;

  function automatic int unsigned evt_width(input int unsigned key_w);
`ifdef KEY_EVT_TIMESTAMP_EN
    return 2 * key_w + TS_W;
`else
    return 2 * key_w;
`endif
  endfunction

endpackage

// File: rtl/key_event_sequencer_if.sv
// Bus bundle between the sequencer and its environment.
//   PIO side   : pio_address, pio_chipselect, pio_write_n, pio_writedata (to PIO),
//                pio_readdata, pio_irq (from PIO)
//   Event side : evt_valid, evt_data (to consumer), evt_ready (from consumer)
//   Status     : ovf_cnt, busy
// master = sequencer, slave = PIO/consumer environment.
// Optional feature macro: KEY_EVT_TIMESTAMP_EN widens evt_data by the timestamp.
interface key_event_sequencer_if #(
  parameter int unsigned KEY_W = 4
) ();
  import key_evt_pkg::*;

  localparam int unsigned EVT_W = evt_width(KEY_W);

  logic [1:0]       pio_address;
  logic             pio_chipselect;
  logic             pio_write_n;
  logic [31:0]      pio_writedata;
  logic [31:0]      pio_readdata;
  logic             pio_irq;
  logic             evt_valid;
  logic             evt_ready;
  logic [EVT_W-1:0] evt_data;
  logic [7:0]       ovf_cnt;
  logic             busy;

  modport master (
    output pio_address, pio_chipselect, pio_write_n, pio_writedata,
    input  pio_readdata, pio_irq,
    output evt_valid, evt_data, ovf_cnt, busy,
    input  evt_ready
  );

  modport slave (
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
    output pio_readdata, pio_irq,
    input  evt_valid, evt_data, ovf_cnt, busy,
    output evt_ready
  );

endinterface

// File: rtl/key_evt_fifo.sv
// First-word fall-through synchronous FIFO.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   i_push     : write i_data (accepted when not full, or when a pop happens this cycle)
//   i_pop      : drop the head entry (ignored when empty)
//   o_data     : current head entry
//   o_full     : all DEPTH entries used
//   o_empty    : no entries
module key_evt_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_en = i_pop && !o_empty;
  // A simultaneous pop frees the slot the push lands in.
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_sequencer.sv
// Avalon-MM master owning a KEY_W-bit key PIO. Initialises the IRQ mask and clears stale
// captures, then services each PIO interrupt: read+clear edge capture, read key levels,
// and queue {levels, edges} in a FWFT FIFO drained over a valid/ready stream.
//   clk, reset : clock, asynchronous active-high reset (restarts the init sequence)
//   bus        : key_event_sequencer_if.master (PIO bus, event stream, ovf_cnt, busy)
// Optional feature macro: KEY_EVT_TIMESTAMP_EN prepends a 16-bit cycle-count timestamp
// (sampled when the capture register is read back) to each event.
module key_event_sequencer import key_evt_pkg::*; #(
  parameter int unsigned      KEY_W      = 4,
  parameter logic [KEY_W-1:0] IRQ_MASK   = 4'hF,
  parameter int unsigned      FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  key_event_sequencer_if.master bus
);
  localparam int unsigned EVT_W = evt_width(KEY_W);

  state_e           r_state;
  logic [1:0]       r_addr;
  logic             r_cs;
  logic             r_write_n;
  logic [31:0]      r_wdata;
  logic             r_busy;
  logic [KEY_W-1:0] r_edges;
  logic [KEY_W-1:0] r_levels;
  logic [7:0]       r_ovf;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [EVT_W-1:0] w_fifo_din;

  assign bus.pio_address    = r_addr;
  assign bus.pio_chipselect = r_cs;
  assign bus.pio_write_n    = r_write_n;
  assign bus.pio_writedata  = r_wdata;
  assign bus.busy           = r_busy;
  assign bus.ovf_cnt        = r_ovf;
  assign bus.evt_valid      = !w_empty;

  // Each access strobe is issued on entry to the state named after it, so the state and its
  // bus cycle coincide; the init writes are issued on leaving the init states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StInitMask;
      r_addr    <= '0;
      r_cs      <= 1'b0;
      r_write_n <= 1'b1;
      r_wdata   <= '0;
      r_busy    <= 1'b1;
      r_edges   <= '0;
      r_levels  <= '0;
    end else begin
      r_cs      <= 1'b0;
      r_write_n <= 1'b1;
      r_busy    <= (r_state != StIdle);
      unique case (r_state)
        StInitMask: begin
          r_cs      <= 1'b1;
          r_write_n <= 1'b0;
          r_addr    <= ADDR_MASK;
          r_wdata   <= 32'(IRQ_MASK);
          r_state   <= StInitClr;
        end
        StInitClr: begin
          r_cs      <= 1'b1;
          r_write_n <= 1'b0;
          r_addr    <= ADDR_CAP;
          r_wdata   <= '0;
          r_state   <= StIdle;
        end
        StIdle: begin
          if (bus.pio_irq) begin
            r_cs    <= 1'b1;
            r_addr  <= ADDR_CAP;
            r_state <= StRdCap;
          end
        end
        StRdCap: r_state <= StCapWait;
        StCapWait: begin
          r_edges <= bus.pio_readdata[KEY_W-1:0];
          if (bus.pio_readdata[KEY_W-1:0] == '0) begin
            r_state <= StIdle;
          end else begin
            r_cs      <= 1'b1;
            r_write_n <= 1'b0;
            r_addr    <= ADDR_CAP;
            r_wdata   <= '0;
            r_state   <= StClr;
          end
        end
        StClr: begin
          r_cs    <= 1'b1;
          r_addr  <= ADDR_DATA;
          r_state <= StRdDat;
        end
        StRdDat: r_state <= StDatWait;
        StDatWait: begin
          r_levels <= bus.pio_readdata[KEY_W-1:0];
          r_state  <= StPush;
        end
        StPush:  r_state <= StIdle;
        default: r_state <= StInitMask;
      endcase
    end
  end

`ifdef KEY_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_ts_smp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts     <= '0;
      r_ts_smp <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (r_state == StCapWait) begin
        r_ts_smp <= r_ts;
      end
    end
  end

  assign w_fifo_din = {r_ts_smp, r_levels, r_edges};
`else
  assign w_fifo_din = {r_levels, r_edges};
`endif

  assign w_push = (r_state == StPush);
  assign w_pop  = !w_empty && bus.evt_ready;

  // Only a push into a full FIFO with no concurrent pop is a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= '0;
    end else if (w_push && w_full && !w_pop && (r_ovf != 8'hFF)) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end

  key_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_fifo_din),
    .i_pop   (w_pop),
    .o_data  (bus.evt_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_key_event_sequencer.sv
// Self-checking bench for key_event_sequencer: PIO slave model, directed vector table,
// hand-written corner sequences and a randomized run against a queue-based event model.
module tb_key_event_sequencer;
  import key_evt_pkg::*;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  key_event_sequencer_if #(.KEY_W(KEY_W)) bus ();

  key_event_sequencer #(
    .KEY_W      (KEY_W),
    .IRQ_MASK   (4'hF),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.pio_chipselect && !bus.pio_write_n) n_wr <= n_wr + 1;

  // PIO slave model: registered read data, write to capture clears it, irq = capture & mask.
  logic [3:0]  pio_cap;
  logic [3:0]  pio_mask;
  logic [3:0]  key_lvl = 4'h0;
  logic [3:0]  press = 4'h0;
  logic        force_irq = 1'b0;
  logic [31:0] rdata_q;
  logic [3:0]  cap_n;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pio_cap  <= '0;
      pio_mask <= '0;
      rdata_q  <= '0;
    end else begin
      cap_n = pio_cap;
      if (bus.pio_chipselect && !bus.pio_write_n) begin
        if (bus.pio_address == 2'd2) pio_mask <= bus.pio_writedata[3:0];
        if (bus.pio_address == 2'd3) cap_n = 4'h0;
      end
      pio_cap <= cap_n | press;
      if (bus.pio_chipselect && bus.pio_write_n) begin
        case (bus.pio_address)
          2'd0:    rdata_q <= {28'h0, key_lvl};
          2'd2:    rdata_q <= {28'h0, pio_mask};
          2'd3:    rdata_q <= {28'h0, pio_cap};
          default: rdata_q <= '0;
        endcase
      end
    end
  end

  assign bus.pio_readdata = rdata_q;
  assign bus.pio_irq      = (|(pio_cap & pio_mask)) | force_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Call at a negedge; asserts reset, checks reset values, releases and checks init writes.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_cs", bus.pio_chipselect, 1'b0);
    chk("rst_wn", bus.pio_write_n, 1'b1);
    chk("rst_addr", bus.pio_address, 2'd0);
    chk("rst_wdata", bus.pio_writedata, 32'h0);
    chk("rst_valid", bus.evt_valid, 1'b0);
    chk("rst_data", bus.evt_data[7:0], 8'h00);
    chk("rst_ovf", bus.ovf_cnt, 8'h00);
    chk("rst_busy", bus.busy, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("init1_cs", bus.pio_chipselect, 1'b1);
    chk("init1_wn", bus.pio_write_n, 1'b0);
    chk("init1_addr", bus.pio_address, 2'd2);
    chk("init1_wdata", bus.pio_writedata, 32'hF);
    chk("init1_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk("init2_cs", bus.pio_chipselect, 1'b1);
    chk("init2_wn", bus.pio_write_n, 1'b0);
    chk("init2_addr", bus.pio_address, 2'd3);
    chk("init2_wdata", bus.pio_writedata, 32'h0);
    chk("init2_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk("init3_cs", bus.pio_chipselect, 1'b0);
    chk("init3_busy", bus.busy, 1'b0);
  endtask

  // Start a key press at a negedge; returns at the negedge of the cycle irq is first seen.
  task automatic start_press(input logic [3:0] cap, input logic [3:0] lvl);
    key_lvl = lvl;
    press   = cap;
    @(negedge clk);
    press = 4'h0;
  endtask

  // Full service with no checks; returns when the event is visible (if the FIFO had room).
  task automatic svc(input logic [3:0] cap, input logic [3:0] lvl);
    start_press(cap, lvl);
    repeat (7) @(negedge clk);
  endtask

  logic [7:0] exp_q[$];

  task automatic drain(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({name, "_valid"}, bus.evt_valid, 1'b1);
      chk({name, "_data"}, bus.evt_data[7:0], exp_q[i]);
      bus.evt_ready = 1'b1;
      @(negedge clk);
    end
    bus.evt_ready = 1'b0;
    chk({name, "_empty"}, bus.evt_valid, 1'b0);
  endtask

  typedef struct {
    logic [3:0] cap;
    logic [3:0] lvl;
    logic       spur;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vec[6];
  int         wr0;
  int         off0;
  logic [7:0] model_q[$];
  int         ovf_m;
  int         next_press;
  int         push_cyc;
  logic [7:0] push_val;
  logic [3:0] cap;
  logic       rdy;
  logic       pop;
  logic       full;

  initial begin
    bus.evt_ready = 1'b0;

    vec[0] = '{cap: 4'h2, lvl: 4'hD, spur: 1'b0, exp_valid: 1'b1, exp_data: 8'hD2};
    vec[1] = '{cap: 4'h1, lvl: 4'h0, spur: 1'b0, exp_valid: 1'b1, exp_data: 8'h01};
    vec[2] = '{cap: 4'h0, lvl: 4'h5, spur: 1'b1, exp_valid: 1'b0, exp_data: 8'h00};
    vec[3] = '{cap: 4'h8, lvl: 4'hF, spur: 1'b0, exp_valid: 1'b1, exp_data: 8'hF8};
    vec[4] = '{cap: 4'hF, lvl: 4'hA, spur: 1'b0, exp_valid: 1'b1, exp_data: 8'hAF};
    vec[5] = '{cap: 4'h4, lvl: 4'h4, spur: 1'b0, exp_valid: 1'b1, exp_data: 8'h44};

    @(negedge clk);
    do_reset();

    // Vector table: single services with bus timing checks relative to irq cycle c.
    for (int i = 0; i < 6; i++) begin
      wr0     = n_wr;
      key_lvl = vec[i].lvl;
      if (vec[i].spur) begin
        force_irq = 1'b1;
        off0      = 1;
      end else begin
        press = vec[i].cap;
        off0  = 0;
      end
      for (int off = off0; off <= 7; off++) begin
        @(negedge clk);
        press     = 4'h0;
        force_irq = 1'b0;
        if (off == 1) begin
          chk("tv_rdcap_cs", bus.pio_chipselect, 1'b1);
          chk("tv_rdcap_wn", bus.pio_write_n, 1'b1);
          chk("tv_rdcap_addr", bus.pio_address, 2'd3);
        end else if (off == 2) begin
          chk("tv_capwait_cs", bus.pio_chipselect, 1'b0);
          chk("tv_capwait_addr", bus.pio_address, 2'd3);
        end else if (off == 3) begin
          chk("tv_clr_cs", bus.pio_chipselect, !vec[i].spur);
          if (!vec[i].spur) begin
            chk("tv_clr_wn", bus.pio_write_n, 1'b0);
            chk("tv_clr_addr", bus.pio_address, 2'd3);
            chk("tv_clr_wdata", bus.pio_writedata, 32'h0);
          end
        end else if (off == 4) begin
          chk("tv_busy4", bus.busy, !vec[i].spur);
          if (!vec[i].spur) begin
            chk("tv_rddat_cs", bus.pio_chipselect, 1'b1);
            chk("tv_rddat_wn", bus.pio_write_n, 1'b1);
            chk("tv_rddat_addr", bus.pio_address, 2'd0);
          end
        end else if (off == 5) begin
          if (!vec[i].spur) begin
            chk("tv_datwait_cs", bus.pio_chipselect, 1'b0);
            chk("tv_datwait_addr", bus.pio_address, 2'd0);
          end
        end else if (off == 6) begin
          chk("tv_valid_early", bus.evt_valid, 1'b0);
        end else if (off == 7) begin
          chk("tv_valid", bus.evt_valid, vec[i].exp_valid);
          if (vec[i].exp_valid) chk("tv_data", bus.evt_data[7:0], vec[i].exp_data);
          chk("tv_cap_cleared", pio_cap, 4'h0);
          chk("tv_writes", n_wr - wr0, vec[i].spur ? 0 : 1);
        end
      end
      if (vec[i].exp_valid) begin
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        chk("tv_popped", bus.evt_valid, 1'b0);
      end
    end

    // Five presses into a 4-deep FIFO with no consumer: one drop, then ordered drain.
    svc(4'h1, 4'hA);
    svc(4'h2, 4'hB);
    svc(4'h4, 4'hC);
    svc(4'h8, 4'h3);
    svc(4'h3, 4'h5);
    chk("ovf_one", bus.ovf_cnt, 8'd1);
    exp_q = '{8'hA1, 8'hB2, 8'hC4, 8'h38};
    drain("ovf_drain");

    // Full FIFO, consumer ready exactly in the PUSH cycle: no drop.
    svc(4'h5, 4'h1);
    svc(4'h6, 4'h2);
    svc(4'h7, 4'h3);
    svc(4'h9, 4'h4);
    start_press(4'hA, 4'h6);
    repeat (6) @(negedge clk);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    chk("pp_ovf_kept", bus.ovf_cnt, 8'd1);
    exp_q = '{8'h26, 8'h37, 8'h49, 8'h6A};
    drain("pp_drain");

    // Reset asserted while the CLR write is on the bus.
    svc(4'h1, 4'h1);
    svc(4'h2, 4'h2);
    start_press(4'h4, 4'h7);
    repeat (3) @(negedge clk);
    chk("mid_clr_cs", bus.pio_chipselect, 1'b1);
    chk("mid_clr_wn", bus.pio_write_n, 1'b0);
    do_reset();
    repeat (8) @(negedge clk);
    chk("mid_no_event", bus.evt_valid, 1'b0);
    chk("mid_idle", bus.busy, 1'b0);

    // Randomized run against a queue model of the FIFO and drop counter.
    @(negedge clk);
    do_reset();
    model_q.delete();
    ovf_m      = 0;
    next_press = cyc + 1;
    push_cyc   = -1;
    push_val   = 8'h00;
    for (int n = 0; n < 3600; n++) begin
      @(negedge clk);
      press = 4'h0;
      chk("rnd_valid", bus.evt_valid, model_q.size() != 0);
      if (model_q.size() != 0) chk("rnd_data", bus.evt_data[7:0], model_q[0]);
      chk("rnd_ovf", bus.ovf_cnt, 32'(ovf_m));
      if (cyc == next_press && n < 3350) begin
        cap        = 4'($urandom_range(15, 1));
        key_lvl    = 4'($urandom);
        press      = cap;
        push_val   = {key_lvl, cap};
        // Event is enqueued at the end of the 7th cycle after the press is captured.
        push_cyc   = cyc + 7;
        next_press = cyc + int'($urandom_range(10, 8));
      end
      if (n >= 3400) rdy = 1'b1;
      else if (n >= 600) rdy = 1'b0;
      else rdy = ($urandom_range(3, 0) == 0);
      bus.evt_ready = rdy;
      pop  = rdy && (model_q.size() != 0);
      full = (model_q.size() >= DEPTH);
      if (pop) void'(model_q.pop_front());
      if (cyc == push_cyc) begin
        if (!full || pop) model_q.push_back(push_val);
        else if (ovf_m != 255) ovf_m++;
      end
    end
    @(negedge clk);
    chk("rnd_ovf_sat", bus.ovf_cnt, 8'd255);
    chk("rnd_drained", bus.evt_valid, 1'b0);
    bus.evt_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_event_sequencer.md
# key_event_sequencer

Avalon-MM master that owns the 4-bit key PIO slave (data at address 0, IRQ mask at 2, edge capture at 3). After reset it programs the IRQ mask and clears stale captures. On each PIO interrupt it reads and clears the edge capture, samples the key levels, and pushes a combined event into a small FIFO. The FIFO is drained over a valid/ready stream, so software or downstream logic never touches the PIO registers directly.

## Interface
Parameters:
- KEY_W, 4: key count; must match PIO width.
- IRQ_MASK, 4'hF: value written to PIO mask register at init.
- FIFO_DEPTH, 4: event FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- pio_address  out  2  PIO register address.
- pio_chipselect  out  1  single-cycle access strobe.
- pio_write_n  out  1  active-low write qualifier.
- pio_writedata  out  32  write data.
- pio_readdata  in  32  PIO registered read data.
- pio_irq  in  1  PIO interrupt, level.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts head.
- evt_data  out  2*KEY_W (+16 with timestamp)  {levels, edges} (+ timestamp in MSBs).
- ovf_cnt  out  8  dropped-event count, saturating.
- busy  out  1  FSM not in IDLE.

## Operation
- Reset values: pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0, evt_valid 0, evt_data 0, ovf_cnt 0, busy 1 (INIT pending). FIFO is emptied.
- FSM states and transitions:
  - INIT_MASK: write IRQ_MASK to address 2; go to INIT_CLR.
  - INIT_CLR: write 0 to address 3; go to IDLE.
  - IDLE: on pio_irq=1, go to RD_CAP.
  - RD_CAP: read address 3; go to CAP_WAIT.
  - CAP_WAIT: latch pio_readdata[KEY_W-1:0] as edges. If edges==0 (spurious), go to IDLE; else go to CLR.
  - CLR: write 0 to address 3; go to RD_DAT.
  - RD_DAT: read address 0; go to DAT_WAIT.
  - DAT_WAIT: latch levels; go to PUSH.
  - PUSH: enqueue {levels, edges}; go to IDLE.
- Access rules:
  - Exactly one chipselect cycle per access.
  - Reads hold pio_write_n=1.
  - pio_address is held through the following wait cycle.
- Push when the FIFO is full:
  - Event is dropped and ovf_cnt increments, saturating at 255.
  - If evt_ready=1 in that same cycle, the pop frees space and the push is accepted, with no drop.
- FIFO: first-word fall-through; evt_data is stable while evt_valid=1 and evt_ready=0.
- Edges captured by the PIO between the RD_CAP read and the CLR write are cleared unreported. This is an accepted PIO limitation; the window is 2 cycles.
- Reset mid-operation: all state aborts immediately, pending events are lost, and the sequence restarts at INIT_MASK.

## Timing
- INIT takes 2 cycles after reset deassertion; busy falls in the 3rd cycle.
- pio_readdata for an address presented in cycle N is sampled in cycle N+1.
- Latency: pio_irq high in IDLE at cycle 0 gives evt_valid=1 at cycle 7 when the FIFO was empty.
- pio_irq falls one cycle after the CLR cycle.
- FSM returns to IDLE at cycle 7, so the minimum spacing between services is 7 cycles.
- Pop takes one cycle: the next entry appears the cycle after evt_valid and evt_ready are both 1.

## Configuration
- KEY_EVT_TIMESTAMP_EN defined:
  - A free-running 16-bit cycle counter, reset to 0 and wrapping at 0xFFFF, is sampled in CAP_WAIT.
  - The sample is stored as evt_data[2*KEY_W+15:2*KEY_W].
- KEY_EVT_TIMESTAMP_EN undefined: no counter; evt_data is 2*KEY_W wide.

## Structure
- Package key_evt_pkg holds:
  - state enum;
  - PIO address constants: ADDR_DATA=0, ADDR_MASK=2, ADDR_CAP=3;
  - timestamp width of 16.
- Sub-module key_evt_fifo: parameterised-width/depth synchronous FIFO with full, empty, push and pop.

## Test plan
- Reset release: addr 2 written with 0xF at cycle 1, then addr 3 written with 0 at cycle 2; busy=0 at cycle 3.
- Single key press: PIO model asserts irq with capture=0x2, data=0xD; evt_data=0xD2 and evt_valid at cycle 7; capture cleared.
- Spurious irq with capture reading 0: no CLR write, no event, FSM back in IDLE after CAP_WAIT.
- Five presses with evt_ready=0 and FIFO_DEPTH=4: 4 events queued, ovf_cnt=1. Then drain in order with evt_ready=1.
- Push and pop in the same cycle when full, with evt_ready=1 in PUSH: no drop, ovf_cnt unchanged.
- Reset asserted during CLR: outputs go to reset values at once, FIFO empty, INIT sequence repeats on release.
